// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions against machine interrupts, flushes the
// pipe, then emits one-cycle trap entry/return strobes and PC redirects.
module trap_ctrl #(
    parameter int FLUSH_MAX = 16,
    parameter int CNT_W     = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_req,
    input  logic [4:0]  ex_cause,
    input  logic [31:0] ex_tval,
    input  logic        mret_req,
    input  logic        soft_pending,
    input  logic        time_pending,
    input  logic        ext_pending,
    input  logic        mstatus_mie,
    input  logic [31:0] mie,
    input  logic        pipe_drained,
    output logic        flush,
    output logic        ex_happen,
    output logic        intr_happen,
    output logic [31:0] cause_input,
    output logic [31:0] extra_massage,
    output logic        ex_fin,
    output logic        intr_fin,
    output logic        redirect,
    output logic        redirect_sel,
    output logic        in_trap
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_ENTER,
        S_HANDLER,
        S_RETURN
    } state_t;

    state_t            state_q, state_d;
    logic              kind_ex_q, kind_ex_d;
    logic [31:0]       cause_q, cause_d;
    logic [31:0]       tval_q, tval_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic       elig_soft, elig_time, elig_ext, irq_any, line_ok;
    logic [4:0] irq_code;
    logic       unused_mie;

    assign unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};

    assign elig_soft = mstatus_mie & soft_pending & mie[3];
    assign elig_time = mstatus_mie & time_pending & mie[7];
    assign elig_ext  = mstatus_mie & ext_pending  & mie[11];
    assign irq_any   = elig_soft | elig_time | elig_ext;
    assign irq_code  = elig_ext ? 5'd11 : (elig_soft ? 5'd3 : 5'd7);

    // The interrupt that started a flush must stay eligible, else it is abandoned.
    assign line_ok = ((cause_q[4:0] == 5'd11) & elig_ext)
                   | ((cause_q[4:0] == 5'd3)  & elig_soft)
                   | ((cause_q[4:0] == 5'd7)  & elig_time);

    always_comb begin
        state_d   = state_q;
        kind_ex_d = kind_ex_q;
        cause_d   = cause_q;
        tval_d    = tval_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ex_req) begin
                    state_d   = S_FLUSH;
                    kind_ex_d = 1'b1;
                    cause_d   = {27'b0, ex_cause};
                    tval_d    = ex_tval;
                    cnt_d     = '0;
                end else if (irq_any) begin
                    state_d   = S_FLUSH;
                    kind_ex_d = 1'b0;
                    cause_d   = {1'b1, 26'b0, irq_code};
                    tval_d    = 32'b0;
                    cnt_d     = '0;
                end
            end
            S_FLUSH: begin
                if (!kind_ex_q && ex_req) begin
                    kind_ex_d = 1'b1;
                    cause_d   = {27'b0, ex_cause};
                    tval_d    = ex_tval;
                    cnt_d     = '0;
                end else if (!kind_ex_q && !line_ok) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (pipe_drained || cnt_q == CNT_W'(FLUSH_MAX - 1)) begin
                    state_d = S_ENTER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ENTER: state_d = S_HANDLER;
            S_HANDLER: begin
                if (ex_req) begin
                    state_d   = S_FLUSH;
                    kind_ex_d = 1'b1;
                    cause_d   = {27'b0, ex_cause};
                    tval_d    = ex_tval;
                    cnt_d     = '0;
                end else if (mret_req) begin
                    state_d = S_RETURN;
                end
            end
            S_RETURN: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            kind_ex_q     <= 1'b0;
            cause_q       <= 32'b0;
            tval_q        <= 32'b0;
            cnt_q         <= '0;
            flush         <= 1'b0;
            ex_happen     <= 1'b0;
            intr_happen   <= 1'b0;
            cause_input   <= 32'b0;
            extra_massage <= 32'b0;
            ex_fin        <= 1'b0;
            intr_fin      <= 1'b0;
            redirect      <= 1'b0;
            redirect_sel  <= 1'b0;
            in_trap       <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_ex_q     <= kind_ex_d;
            cause_q       <= cause_d;
            tval_q        <= tval_d;
            cnt_q         <= cnt_d;
            flush         <= (state_d == S_FLUSH);
            ex_happen     <= (state_d == S_ENTER) &&  kind_ex_d;
            intr_happen   <= (state_d == S_ENTER) && !kind_ex_d;
            cause_input   <= (state_d == S_ENTER) ? cause_d : 32'b0;
            extra_massage <= (state_d == S_ENTER) ? tval_d  : 32'b0;
            ex_fin        <= (state_d == S_RETURN) &&  kind_ex_d;
            intr_fin      <= (state_d == S_RETURN) && !kind_ex_d;
            redirect      <= (state_d == S_ENTER) || (state_d == S_RETURN);
            redirect_sel  <= (state_d == S_RETURN);
            in_trap       <= (state_d == S_HANDLER);
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a phase-level reference model.
module tb_trap_ctrl;

    localparam int FLUSH_MAX = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_req, mret_req, soft_pending, time_pending, ext_pending;
    logic        mstatus_mie, pipe_drained;
    logic [4:0]  ex_cause;
    logic [31:0] ex_tval, mie;
    logic        flush, ex_happen, intr_happen, ex_fin, intr_fin;
    logic        redirect, redirect_sel, in_trap;
    logic [31:0] cause_input, extra_massage;

    int n_tests = 0;
    int n_fail  = 0;

    trap_ctrl #(.FLUSH_MAX(FLUSH_MAX), .CNT_W(5)) dut (
        .clk(clk), .resetn(resetn), .ex_req(ex_req), .ex_cause(ex_cause),
        .ex_tval(ex_tval), .mret_req(mret_req), .soft_pending(soft_pending),
        .time_pending(time_pending), .ext_pending(ext_pending),
        .mstatus_mie(mstatus_mie), .mie(mie), .pipe_drained(pipe_drained),
        .flush(flush), .ex_happen(ex_happen), .intr_happen(intr_happen),
        .cause_input(cause_input), .extra_massage(extra_massage),
        .ex_fin(ex_fin), .intr_fin(intr_fin), .redirect(redirect),
        .redirect_sel(redirect_sel), .in_trap(in_trap)
    );

    always #5 clk = ~clk;

    // Reference model: the trap's current phase plus what was captured at request time.
    localparam int P_IDLE = 0, P_FLUSH = 1, P_ENTER = 2, P_HANDLER = 3, P_RETURN = 4;
    int          m_ph;
    bit          m_is_ex;
    int          m_code;
    int          m_wait;
    logic [31:0] m_cause, m_tval;
    int          irq_order[3] = '{11, 3, 7};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit elig(input int code);
        bit pend;
        pend = (code == 3) ? soft_pending : (code == 7) ? time_pending : ext_pending;
        return mstatus_mie && mie[code] && pend;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_is_ex = 0; m_code = 0; m_wait = 0; m_cause = 0; m_tval = 0;
    endtask

    task automatic take_ex();
        m_ph = P_FLUSH; m_is_ex = 1; m_wait = 0;
        m_cause = 32'(ex_cause); m_tval = ex_tval;
    endtask

    task automatic model_tick();
        int c;
        if (!resetn) begin
            model_reset();
            return;
        end
        case (m_ph)
            P_IDLE: begin
                c = -1;
                foreach (irq_order[k]) if (c < 0 && elig(irq_order[k])) c = irq_order[k];
                if (ex_req) take_ex();
                else if (c >= 0) begin
                    m_ph = P_FLUSH; m_is_ex = 0; m_code = c; m_wait = 0;
                    m_cause = 32'h8000_0000 + 32'(c); m_tval = 0;
                end
            end
            P_FLUSH: begin
                if (!m_is_ex && ex_req) take_ex();
                else if (!m_is_ex && !elig(m_code)) m_ph = P_IDLE;
                else if (pipe_drained || m_wait == FLUSH_MAX - 1) m_ph = P_ENTER;
                else m_wait++;
            end
            P_ENTER: m_ph = P_HANDLER;
            P_HANDLER: begin
                if (ex_req) take_ex();
                else if (mret_req) m_ph = P_RETURN;
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic check_all();
        bit ent, ret;
        ent = (m_ph == P_ENTER);
        ret = (m_ph == P_RETURN);
        check_eq("flush",         32'(flush),        32'(m_ph == P_FLUSH));
        check_eq("ex_happen",     32'(ex_happen),    32'(ent && m_is_ex));
        check_eq("intr_happen",   32'(intr_happen),  32'(ent && !m_is_ex));
        check_eq("cause_input",   cause_input,       ent ? m_cause : 32'h0);
        check_eq("extra_massage", extra_massage,     ent ? m_tval : 32'h0);
        check_eq("ex_fin",        32'(ex_fin),       32'(ret && m_is_ex));
        check_eq("intr_fin",      32'(intr_fin),     32'(ret && !m_is_ex));
        check_eq("redirect",      32'(redirect),     32'(ent || ret));
        check_eq("redirect_sel",  32'(redirect_sel), 32'(ret));
        check_eq("in_trap",       32'(in_trap),      32'(m_ph == P_HANDLER));
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        ex_req = 0; ex_cause = 0; ex_tval = 0; mret_req = 0;
        soft_pending = 0; time_pending = 0; ext_pending = 0;
        mstatus_mie = 1; mie = 32'h888; pipe_drained = 1;
    endtask

    task automatic finish_trap();
        soft_pending = 0; time_pending = 0; ext_pending = 0; ex_req = 0;
        step();
        mret_req = 1; step();
        mret_req = 0; step();
    endtask

    initial begin
        int n;
        resetn = 0;
        clear_inputs();
        model_reset();
        repeat (2) step();
        resetn = 1;
        step();

        // Interrupt priority: external beats timer.
        ext_pending = 1; time_pending = 1;
        step();
        check_eq("irq_flush", 32'(flush), 32'h1);
        step();
        check_eq("irq_cause", cause_input, 32'h8000_000B);
        check_eq("irq_strobe", 32'(intr_happen), 32'h1);
        check_eq("irq_sel", 32'(redirect_sel), 32'h0);
        ext_pending = 0; time_pending = 0;
        step();
        mret_req = 1; step();
        check_eq("irq_fin", 32'(intr_fin), 32'h1);
        mret_req = 0; step();

        // Exception beats a pending software interrupt.
        soft_pending = 1; ex_req = 1; ex_cause = 5'd2; ex_tval = 32'hDEAD_BEEF;
        step();
        ex_req = 0;
        step();
        check_eq("ex_strobe", 32'(ex_happen), 32'h1);
        check_eq("ex_no_irq", 32'(intr_happen), 32'h0);
        check_eq("ex_cause", cause_input, 32'h2);
        check_eq("ex_tval", extra_massage, 32'hDEAD_BEEF);
        finish_trap();

        // Forced entry after the flush timeout.
        pipe_drained = 0; time_pending = 1;
        step();
        n = 0;
        while (flush && n < 40) begin
            n++;
            step();
        end
        check_eq("flush_len", 32'(n), 32'd16);
        check_eq("forced_entry", 32'(intr_happen), 32'h1);
        check_eq("forced_cause", cause_input, 32'h8000_0007);
        finish_trap();

        // Interrupt withdrawn during flush.
        time_pending = 1;
        step();
        check_eq("wd_flush", 32'(flush), 32'h1);
        time_pending = 0;
        step();
        check_eq("wd_drop", 32'(flush), 32'h0);
        step();
        check_eq("wd_no_strobe", 32'(intr_happen), 32'h0);
        pipe_drained = 1;

        // Nested exception wins over a simultaneous mret.
        ex_req = 1; ex_cause = 5'd5; ex_tval = 32'h1234;
        step();
        ex_req = 0;
        step(); step();
        check_eq("nest_in_trap", 32'(in_trap), 32'h1);
        ex_req = 1; ex_cause = 5'd7; ex_tval = 32'hABCD; mret_req = 1;
        step();
        check_eq("nest_reflush", 32'(flush), 32'h1);
        ex_req = 0; mret_req = 0;
        step();
        check_eq("nest_cause", cause_input, 32'h7);
        step();
        mret_req = 1; step();
        check_eq("nest_fin", 32'(ex_fin), 32'h1);
        check_eq("nest_sel", 32'(redirect_sel), 32'h1);
        mret_req = 0; step();

        // Asynchronous reset while the handler runs.
        ext_pending = 1;
        step(); step();
        ext_pending = 0;
        step();
        check_eq("rst_pre", 32'(in_trap), 32'h1);
        #2 resetn = 0;
        #1;
        model_reset();
        check_all();
        check_eq("rst_in_trap", 32'(in_trap), 32'h0);
        step();
        resetn = 1;
        step();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if (ex_req) begin
                if (m_ph != P_IDLE && m_ph != P_HANDLER && $urandom_range(1, 0) == 1) ex_req = 0;
            end else if ($urandom_range(15, 0) == 0) begin
                ex_req = 1; ex_cause = 5'($urandom); ex_tval = $urandom;
            end
            mret_req = ($urandom_range(7, 0) == 0);
            if ($urandom_range(7, 0) == 0) soft_pending = ~soft_pending;
            if ($urandom_range(7, 0) == 0) time_pending = ~time_pending;
            if ($urandom_range(7, 0) == 0) ext_pending  = ~ext_pending;
            if ($urandom_range(63, 0) == 0) mie = $urandom;
            if ($urandom_range(63, 0) == 0) mie = 32'h888;
            mstatus_mie  = ($urandom_range(9, 0) != 0);
            pipe_drained = ($urandom_range(9, 0) < 3);
            if ($urandom_range(499, 0) == 0) begin
                #2 resetn = 0;
                #1;
                model_reset();
                check_all();
                step();
                resetn = 1;
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
